// File: rtl/jtsdram_mcheck_if.sv
// ---------------------------------------------------------------------------
// jtsdram_mcheck_if
// Bank request/response bundle between the SDRAM memory checker and the
// SDRAM controller it exercises.
//   ba_addr   : word address per bank (BANKS*AW)
//   ba_rd     : read request per bank
//   ba_wr     : write request per bank
//   ba_din    : write data per bank (BANKS*16)
//   ba_din_m  : write byte mask per bank (BANKS*2)
//   ba_ack    : request accepted, per bank
//   ba_rdy    : read data valid / write complete, per bank
//   data_read : shared read data bus, low 16 bits carry the word
// master = checker side, slave = controller side.
// ---------------------------------------------------------------------------
interface jtsdram_mcheck_if #(
  parameter int BANKS = 4,
  parameter int AW    = 22
);
  logic [BANKS*AW-1:0] ba_addr;
  logic [BANKS-1:0]    ba_rd;
  logic [BANKS-1:0]    ba_wr;
  logic [BANKS*16-1:0] ba_din;
  logic [BANKS*2-1:0]  ba_din_m;
  logic [BANKS-1:0]    ba_ack;
  logic [BANKS-1:0]    ba_rdy;
  logic [31:0]         data_read;

  modport master (
    output ba_addr, ba_rd, ba_wr, ba_din, ba_din_m,
    input  ba_ack, ba_rdy, data_read
  );

  modport slave (
    input  ba_addr, ba_rd, ba_wr, ba_din, ba_din_m,
    output ba_ack, ba_rdy, data_read
  );
endinterface

// File: rtl/jtsdram_mcheck.sv
// ---------------------------------------------------------------------------
// jtsdram_mcheck
// SDRAM memory checker. One independent FSM per bank walks 2^CNTW words,
// optionally writing a per-bank address-derived pattern first, then reading
// every word back and comparing it against the same pattern.
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   start     : pulse that launches a pass (ignored while busy)
//   bank_we   : per bank, 1 = write pass then read pass, 0 = read-only pass
//   bus       : bank request/response bundle (master side)
//   busy      : at least one bank is mid-pass
//   done      : one-cycle pulse when the last bank finishes
//   bad       : sticky per-bank mismatch flag
//   err_cnt   : per-bank saturating mismatch counter (BANKS*ERRW)
//   fail_addr : address of the first mismatch per bank (BANKS*AW)
// ---------------------------------------------------------------------------
module jtsdram_mcheck #(
  parameter int          BANKS = 4,
  parameter int          AW    = 22,
  parameter int          CNTW  = 8,
  parameter int          ERRW  = 8,
  parameter logic [15:0] PAT   = 16'h5A3C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BANKS-1:0]    bank_we,
  jtsdram_mcheck_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [BANKS-1:0]    bad,
  output logic [BANKS*ERRW-1:0] err_cnt,
  output logic [BANKS*AW-1:0] fail_addr
);

  typedef enum logic [2:0] {IDLE, WR, WWAIT, RD, RWAIT, DONE} state_e;

  logic [BANKS-1:0]    activeVec;
  logic [BANKS-1:0]    finVec;
  logic [BANKS-1:0]    rdVec;
  logic [BANKS-1:0]    wrVec;
  logic [BANKS*AW-1:0] addrVec;
  logic [BANKS*16-1:0] dinVec;
  logic                launch;
  logic                allDone;
  logic                allDone_q;

  // A start pulse only counts when no bank is mid-pass.
  assign launch  = start & ~busy;
  assign busy    = |activeVec;
  assign allDone = &finVec;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    // Bank index folded into the top two data bits so banks carry distinct data.
    localparam logic [15:0] BTAG = 16'((b % 4) << 14);

    state_e          st_q;
    logic [CNTW-1:0] cnt_q;
    logic            rd_q;
    logic            wr_q;
    logic            bad_q;
    logic [ERRW-1:0] err_q;
    logic [AW-1:0]   fail_q;
    logic [AW-1:0]   addr;
    logic [31:0]     addr32;
    logic [15:0]     expData;
    logic            lastWord;
    logic            mismatch;

    // Address is the zero-extended word counter; the expected word is derived
    // from its low 16 bits so write data and read checks always agree.
    always_comb begin
      addr    = AW'(cnt_q);
      addr32  = 32'(addr);
      expData = addr32[15:0] ^ PAT ^ BTAG;
    end

    assign lastWord = &cnt_q;
    assign mismatch = bus.data_read[15:0] != expData;

    // Per-bank sequencer. Requests are registered and stay high until ack;
    // the counter is only advanced on rdy so addr/din hold while pending.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        rd_q   <= 1'b0;
        wr_q   <= 1'b0;
        bad_q  <= 1'b0;
        err_q  <= '0;
        fail_q <= '0;
      end else begin
        case (st_q)
          IDLE, DONE: begin
            if (launch) begin
              bad_q  <= 1'b0;
              err_q  <= '0;
              fail_q <= '0;
              cnt_q  <= '0;
              if (bank_we[b]) begin
                st_q <= WR;
                wr_q <= 1'b1;
              end else begin
                st_q <= RD;
                rd_q <= 1'b1;
              end
            end
          end
          WR: begin
            if (bus.ba_ack[b]) begin
              wr_q <= 1'b0;
              st_q <= WWAIT;
            end
          end
          WWAIT: begin
            if (bus.ba_rdy[b]) begin
              if (lastWord) begin
                cnt_q <= '0;
                st_q  <= RD;
                rd_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNTW'(1);
                st_q  <= WR;
                wr_q  <= 1'b1;
              end
            end
          end
          RD: begin
            if (bus.ba_ack[b]) begin
              rd_q <= 1'b0;
              st_q <= RWAIT;
            end
          end
          RWAIT: begin
            if (bus.ba_rdy[b]) begin
              // fail_addr keeps the first bad word; later errors only count.
              if (mismatch) begin
                bad_q <= 1'b1;
                if (!(&err_q)) err_q <= err_q + ERRW'(1);
                if (!bad_q) fail_q <= addr;
              end
              if (lastWord) begin
                st_q <= DONE;
              end else begin
                cnt_q <= cnt_q + CNTW'(1);
                st_q  <= RD;
                rd_q  <= 1'b1;
              end
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end

    assign rdVec[b]                = rd_q;
    assign wrVec[b]                = wr_q;
    assign addrVec[b*AW +: AW]     = addr;
    assign dinVec[b*16 +: 16]      = (st_q == WR) ? expData : 16'd0;
    assign finVec[b]               = (st_q == DONE);
    assign activeVec[b]            = (st_q != IDLE) && (st_q != DONE);
    assign bad[b]                  = bad_q;
    assign err_cnt[b*ERRW +: ERRW] = err_q;
    assign fail_addr[b*AW +: AW]   = fail_q;
  end

  // done fires on the cycle all banks have just reached DONE; a reset drops
  // every bank to IDLE, so an aborted pass never produces the pulse.
  always_ff @(posedge clk) begin
    if (rst) allDone_q <= 1'b0;
    else     allDone_q <= allDone;
  end

  assign done         = allDone & ~allDone_q;
  assign bus.ba_rd    = rdVec;
  assign bus.ba_wr    = wrVec;
  assign bus.ba_addr  = addrVec;
  assign bus.ba_din   = dinVec;
  assign bus.ba_din_m = '0;

endmodule

// File: tb/tb_jtsdram_mcheck.sv
// ---------------------------------------------------------------------------
// tb_jtsdram_mcheck
// Self-checking bench: a behavioural SDRAM responder with random latencies,
// a reference model predicting per-bank results of each pass, and a monitor
// that compares the DUT's flags and traffic counts when done pulses.
// ---------------------------------------------------------------------------
module tb_jtsdram_mcheck;
  localparam int          BANKS = 4;
  localparam int          AW    = 22;
  localparam int          CNTW  = 8;
  localparam int          ERRW  = 8;
  localparam int          WORDS = 256;
  localparam logic [15:0] PAT   = 16'h5A3C;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [BANKS-1:0]      bank_we = '0;
  logic                  busy;
  logic                  done;
  logic [BANKS-1:0]      bad;
  logic [BANKS*ERRW-1:0] err_cnt;
  logic [BANKS*AW-1:0]   fail_addr;

  jtsdram_mcheck_if #(.BANKS(BANKS), .AW(AW)) bus ();

  jtsdram_mcheck #(
    .BANKS(BANKS), .AW(AW), .CNTW(CNTW), .ERRW(ERRW), .PAT(PAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bank_we  (bank_we),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .bad      (bad),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int passCount  = 0;

  // Data a healthy checker must write/expect: word ^ seed ^ (bank << 14).
  function automatic logic [15:0] pattern(input int b, input int a);
    int v;
    v = a ^ int'(PAT) ^ (b << 14);
    return v[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // SDRAM model state
  logic [15:0]   mem  [BANKS][WORDS];
  logic [15:0]   corr [BANKS][WORDS];
  int            rsState [BANKS];
  int            rsCnt   [BANKS];
  logic          rsWrite [BANKS];
  logic [AW-1:0] rsAddr  [BANKS];
  logic [15:0]   rsDin   [BANKS];
  int            nWr [BANKS];
  int            nRd [BANKS];
  int            seqBad     = 0;
  int            stableBad  = 0;
  int            overlapBad = 0;

  // Responder: accepts one request per bank, acks after 0-2 cycles and
  // completes after 0-3 more. Only one read may use data_read per cycle.
  // Idle banks occasionally see stray ack/rdy pulses.
  initial begin
    logic busUsed;
    logic req;
    for (int b = 0; b < BANKS; b++) begin
      rsState[b] = 0;
      nWr[b] = 0;
      nRd[b] = 0;
      for (int a = 0; a < WORDS; a++) mem[b][a] = pattern(b, a);
    end
    bus.ba_ack = '0;
    bus.ba_rdy = '0;
    bus.data_read = '0;
    forever begin
      @(negedge clk);
      bus.ba_ack = '0;
      bus.ba_rdy = '0;
      busUsed = 1'b0;
      if ((bus.ba_rd & bus.ba_wr) != '0) overlapBad++;
      if (rst) begin
        for (int b = 0; b < BANKS; b++) rsState[b] = 0;
      end else begin
        if (start && !busy) begin
          for (int b = 0; b < BANKS; b++) begin
            nWr[b] = 0;
            nRd[b] = 0;
          end
        end
        for (int b = 0; b < BANKS; b++) begin
          req = bus.ba_rd[b] | bus.ba_wr[b];
          if (rsState[b] == 0) begin
            if (req) begin
              rsWrite[b] = bus.ba_wr[b];
              rsAddr[b]  = bus.ba_addr[b*AW +: AW];
              rsDin[b]   = bus.ba_din[b*16 +: 16];
              rsCnt[b]   = int'($urandom_range(0, 2));
              rsState[b] = 1;
            end else if ($urandom_range(0, 7) == 0) begin
              if ($urandom_range(0, 1) == 1) bus.ba_ack[b] = 1'b1;
              else                           bus.ba_rdy[b] = 1'b1;
            end
          end
          if (rsState[b] == 1) begin
            if (!(rsWrite[b] ? bus.ba_wr[b] : bus.ba_rd[b]) ||
                bus.ba_addr[b*AW +: AW] != rsAddr[b] ||
                bus.ba_din[b*16 +: 16] != rsDin[b]) stableBad++;
            if (rsCnt[b] == 0) begin
              bus.ba_ack[b] = 1'b1;
              rsCnt[b] = int'($urandom_range(0, 3));
              rsState[b] = 2;
            end else begin
              rsCnt[b]--;
            end
          end else if (rsState[b] == 2) begin
            if (rsCnt[b] > 0) begin
              rsCnt[b]--;
            end else if (rsWrite[b]) begin
              if (rsAddr[b] != AW'(nWr[b]) || rsDin[b] != pattern(b, nWr[b])) seqBad++;
              mem[b][rsAddr[b][CNTW-1:0]] = rsDin[b];
              nWr[b]++;
              bus.ba_rdy[b] = 1'b1;
              rsState[b] = 0;
            end else if (!busUsed) begin
              if (rsAddr[b] != AW'(nRd[b])) seqBad++;
              bus.data_read = {16'($urandom),
                               mem[b][rsAddr[b][CNTW-1:0]] ^ corr[b][rsAddr[b][CNTW-1:0]]};
              busUsed = 1'b1;
              nRd[b]++;
              bus.ba_rdy[b] = 1'b1;
              rsState[b] = 0;
            end
          end
        end
      end
    end
  end

  // Scoreboard entry: predicted per-bank error totals and traffic for a pass.
  typedef struct packed {
    logic [BANKS-1:0][31:0] errs;
    logic [BANKS-1:0][31:0] fail;
    logic [BANKS-1:0][31:0] nwr;
    logic [BANKS-1:0][31:0] nrd;
  } exp_t;

  exp_t expQ[$];
  int   doneSeen = 0;
  int   doneWide = 0;
  int   unexpectedDone = 0;

  // Monitor: every done pulse retires one predicted pass.
  initial begin
    exp_t e;
    logic doneLast;
    int   sat;
    doneLast = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        doneSeen++;
        if (doneLast) begin
          doneWide++;
        end else if (expQ.size() == 0) begin
          unexpectedDone++;
        end else begin
          e = expQ.pop_front();
          for (int b = 0; b < BANKS; b++) begin
            sat = (int'(e.errs[b]) > (2**ERRW - 1)) ? (2**ERRW - 1) : int'(e.errs[b]);
            checkOutput($sformatf("bad[%0d]", b), 64'(bad[b]), 64'(e.errs[b] != 0));
            checkOutput($sformatf("err_cnt[%0d]", b), 64'(err_cnt[b*ERRW +: ERRW]), 64'(sat));
            checkOutput($sformatf("fail_addr[%0d]", b), 64'(fail_addr[b*AW +: AW]),
                        (e.errs[b] != 0) ? 64'(e.fail[b]) : 64'd0);
            checkOutput($sformatf("writes[%0d]", b), 64'(nWr[b]), 64'(e.nwr[b]));
            checkOutput($sformatf("reads[%0d]", b), 64'(nRd[b]), 64'(e.nrd[b]));
          end
        end
      end
      doneLast = done;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearCorr();
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < WORDS; a++) corr[b][a] = 16'd0;
  endtask

  task automatic addRandomCorr(input int count);
    for (int i = 0; i < count; i++)
      corr[$urandom_range(0, BANKS-1)][$urandom_range(0, WORDS-1)] = 16'($urandom_range(1, 65535));
  endtask

  task automatic pulseStart(input logic [BANKS-1:0] we);
    @(posedge clk); #1;
    bank_we = we;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bank_we = BANKS'($urandom);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Launch one pass: predict its outcome, optionally check the flags were
  // cleared, optionally try a second start mid-pass, then wait for retirement.
  task automatic applyStimulus(input logic [BANKS-1:0] we, input bit checkClear,
                               input bit interfere);
    exp_t e;
    int   cyc;
    e = '0;
    for (int b = 0; b < BANKS; b++) begin
      int cnt;
      int first;
      cnt = 0;
      first = 0;
      for (int a = 0; a < WORDS; a++) begin
        if (corr[b][a] != 16'd0) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
      e.errs[b] = 32'(cnt);
      e.fail[b] = 32'(first);
      e.nwr[b]  = we[b] ? 32'(WORDS) : 32'd0;
      e.nrd[b]  = 32'(WORDS);
    end
    expQ.push_back(e);
    passCount++;
    $display("[TB] pass %0d: bank_we=%b", passCount, we);
    pulseStart(we);
    if (checkClear) begin
      checkOutput("bad_cleared", 64'(bad), 64'd0);
      checkOutput("err_cnt_cleared", 64'(err_cnt), 64'd0);
      checkOutput("fail_addr_cleared", 64'(fail_addr), 64'd0);
    end
    if (interfere) begin
      repeat ($urandom_range(50, 300)) @(posedge clk);
      pulseStart(~we);
    end
    cyc = 0;
    while (expQ.size() != 0 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL pass_timeout: pass %0d still pending after %0d cycles, expected done",
               passCount, cyc);
      expQ.delete();
      pulseReset();
    end
    repeat (3) @(posedge clk);
  endtask

  // Abort a write pass while bank 0 waits for rdy.
  task automatic resetMidWrite();
    int cyc;
    pulseStart(4'b0001);
    cyc = 0;
    while (!(rsState[0] == 2 && rsWrite[0] && !bus.ba_wr[0]) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("wwait_reached", 64'(cyc < 2000), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ba_rd", 64'(bus.ba_rd), 64'd0);
    checkOutput("abort_ba_wr", 64'(bus.ba_wr), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  initial begin
    logic [BANKS-1:0] we;
    $display("[TB] start");
    clearCorr();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ba_rd", 64'(bus.ba_rd), 64'd0);
    checkOutput("rst_ba_wr", 64'(bus.ba_wr), 64'd0);
    checkOutput("rst_ba_addr", 64'(bus.ba_addr), 64'd0);
    checkOutput("rst_ba_din", 64'(bus.ba_din), 64'd0);
    checkOutput("rst_ba_din_m", 64'(bus.ba_din_m), 64'd0);
    checkOutput("rst_bad", 64'(bad), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("rst_fail_addr", 64'(fail_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Bank 0 writes then reads, others read the preloaded pattern.
    applyStimulus(4'b0001, 1'b0, 1'b0);

    // Two corrupted words on bank 2.
    corr[2][16'h10] = 16'($urandom_range(1, 65535));
    corr[2][16'h20] = 16'($urandom_range(1, 65535));
    applyStimulus(BANKS'($urandom), 1'b0, 1'b0);

    // Every bank-1 read wrong: counter saturates.
    clearCorr();
    for (int a = 0; a < WORDS; a++) corr[1][a] = 16'($urandom_range(1, 65535));
    applyStimulus(4'b0010, 1'b0, 1'b0);

    // Clean pass right after a failing one: flags clear on start.
    clearCorr();
    applyStimulus(BANKS'($urandom), 1'b1, 1'b0);

    // Second start while busy is ignored.
    addRandomCorr(3);
    applyStimulus(BANKS'($urandom), 1'b0, 1'b1);

    // Random passes.
    for (int i = 0; i < 2; i++) begin
      clearCorr();
      addRandomCorr(int'($urandom_range(0, 5)));
      we = BANKS'($urandom);
      applyStimulus(we, 1'b1, 1'b0);
    end

    // Abort mid-write, then recover with a full write pass.
    clearCorr();
    resetMidWrite();
    addRandomCorr(2);
    applyStimulus(4'b1111, 1'b1, 1'b0);

    checkOutput("rd_wr_overlap", 64'(overlapBad), 64'd0);
    checkOutput("request_stability", 64'(stableBad), 64'd0);
    checkOutput("addr_data_sequence", 64'(seqBad), 64'd0);
    checkOutput("done_width", 64'(doneWide), 64'd0);
    checkOutput("unexpected_done", 64'(unexpectedDone), 64'd0);
    checkOutput("done_count", 64'(doneSeen), 64'(passCount));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
